// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit between pipeline and word-wide data memory
// Optional feature macro: SUBWORD_EN (byte and half-word accesses with read-merge stores)
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_err;
  logic        w_range_err;
  logic        w_size_err;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        r_mem_write;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_write_data;

`ifdef SUBWORD_EN
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata_lo;

  // Pick the addressed lane(s) out of a memory word and extend to 32 bits.
  function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic sgn, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   f_extract = {{24{sgn & b[7]}}, b};
      2'b01:   f_extract = {{16{sgn & h[15]}}, h};
      default: f_extract = word;
    endcase
  endfunction

  // Replace only the addressed lane(s) of the old word with the new store data.
  function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane, input logic [15:0] wd);
    f_merge = word;
    if (size == 2'b00) begin
      f_merge[{lane, 3'b000} +: 8] = wd[7:0];
    end else if (lane[1]) begin
      f_merge[31:16] = wd;
    end else begin
      f_merge[15:0] = wd;
    end
  endfunction

  assign w_size_err = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
  // Only aligned word accesses exist in this build; sign control is meaningless.
  logic w_unused_ok;
  assign w_unused_ok = req_signed;
  assign w_size_err  = (req_size != 2'b10) || (req_addr[1:0] != 2'b00);
`endif

  assign w_range_err = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
  assign w_err       = w_size_err || w_range_err;
  assign w_accept    = req_valid && (r_state == IDLE);

  assign req_ready      = (r_state == IDLE);
  assign resp_valid     = (r_state == RESP);
  assign resp_error     = (r_state == RESP) && r_err;
  assign resp_rdata     = (r_state == RESP) ? r_rdata : 32'd0;
  assign mem_write      = r_mem_write;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_write_data;

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state: errors skip memory, loads read, word stores write, sub-word stores read then write.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err)                 w_next = RESP;
          else if (!req_write)       w_next = RD;
          else if (req_size == 2'b10) w_next = WR;
          else                       w_next = RD;
        end
      end
`ifdef SUBWORD_EN
      RD:      w_next = r_write ? WR : RESP;
`else
      RD:      w_next = RESP;
`endif
      WR:      w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: latch request on accept, drive registered memory port, capture read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err            <= 1'b0;
      r_rdata          <= 32'd0;
      r_mem_write      <= 1'b0;
      r_mem_address    <= 32'd0;
      r_mem_write_data <= 32'd0;
`ifdef SUBWORD_EN
      r_write          <= 1'b0;
      r_size           <= 2'b00;
      r_signed         <= 1'b0;
      r_lane           <= 2'b00;
      r_wdata_lo       <= 16'd0;
`endif
    end else begin
      r_mem_write <= (w_next == WR);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_err   <= w_err;
            r_rdata <= 32'd0;
            if (!w_err) r_mem_address <= {req_addr[31:2], 2'b00};
            if (w_next == WR) r_mem_write_data <= req_wdata;
`ifdef SUBWORD_EN
            r_write    <= req_write;
            r_size     <= req_size;
            r_signed   <= req_signed;
            r_lane     <= req_addr[1:0];
            r_wdata_lo <= req_wdata[15:0];
`endif
          end
        end
        RD: begin
`ifdef SUBWORD_EN
          if (r_write) r_mem_write_data <= f_merge(mem_read_data, r_size, r_lane, r_wdata_lo);
          else         r_rdata <= f_extract(mem_read_data, r_size, r_signed, r_lane);
`else
          r_rdata <= mem_read_data;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = 32'd0;

  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int bad_addr = 0;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Data memory: reads and writes on the falling edge.
  always @(negedge clk) begin
    mem_read_data <= mem[mem_address[7:2]];
    if (mem_write) begin
      mem[mem_address[7:2]] <= mem_write_data;
      wr_cnt = wr_cnt + 1;
      if (mem_address[1:0] != 2'b00 || mem_address[31:8] != 24'd0) bad_addr = bad_addr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] ad);
    logic e;
    e = (sz == 2'd3) || (sz == 2'd1 && ad % 2 != 0) || (sz == 2'd2 && ad % 4 != 0) || (ad / 4 >= 64);
`ifndef SUBWORD_EN
    e = e || (sz != 2'd2);
`endif
    return e;
  endfunction

  function automatic int unsigned model_shift(input logic [1:0] sz, input logic [31:0] ad);
    if (sz == 2'd0) return (ad % 4) * 8;
    if (sz == 2'd1) return ((ad % 4) / 2) * 16;
    return 0;
  endfunction

  function automatic logic [31:0] model_mask(input logic [1:0] sz);
    if (sz == 2'd0) return 32'hFF;
    if (sz == 2'd1) return 32'hFFFF;
    return 32'hFFFF_FFFF;
  endfunction

  // One access; the model predicts error, data, latency, write count and memory effect.
  task automatic access(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd, output logic [31:0] rd);
    logic        e;
    logic [31:0] exp_rd;
    logic [31:0] old;
    logic [31:0] m;
    int unsigned sh;
    int          exp_lat;
    int          lat;
    int          wr0;
    e   = model_err(sz, ad);
    sh  = model_shift(sz, ad);
    old = (ad / 4 < 64) ? ref_mem[ad[7:2]] : 32'd0;
    exp_rd = 32'd0;
    if (e) exp_lat = 1;
    else if (!wr) begin
      exp_lat = 2;
      exp_rd = (old >> sh) & model_mask(sz);
      if (sg && sz == 2'd0 && exp_rd >= 32'd128)   exp_rd = exp_rd + 32'hFFFF_FF00;
      if (sg && sz == 2'd1 && exp_rd >= 32'd32768) exp_rd = exp_rd + 32'hFFFF_0000;
    end else begin
      exp_lat = (sz == 2'd2) ? 2 : 3;
      m = model_mask(sz) << sh;
      ref_mem[ad[7:2]] = (old & ~m) | ((wd << sh) & m);
    end
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    wr0 = wr_cnt;
    @(posedge clk); #1;
    // Keep presenting unrelated stores while busy; they must be ignored.
    req_write = 1'b1; req_size = 2'b10; req_addr = 32'($urandom_range(0, 63)) << 2; req_wdata = $urandom;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (resp_valid) begin lat = n; break; end
    end
    req_valid = 1'b0;
    check("latency", lat, exp_lat);
    check("resp_error", {31'd0, resp_error}, {31'd0, e});
    check("resp_rdata", resp_rdata, exp_rd);
    rd = resp_rdata;
    @(posedge clk); #1;
    check("resp_pulse", {31'd0, resp_valid}, 32'd0);
    @(negedge clk); #1;
    check("write_count", wr_cnt - wr0, (!e && wr) ? 1 : 0);
    if (ad / 4 < 64) check("mem_word", mem[ad[7:2]], ref_mem[ad[7:2]]);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] keep;
    int wr0;
    int seen;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;

    // Word store then word load at 0x08.
    access(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, rd);
    access(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, rd);
    check("deadbeef", rd, 32'hDEADBEEF);

    // Sub-word loads and merge store over 0x80FF7F01.
    access(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, rd);
    access(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, rd);
`ifdef SUBWORD_EN
    check("lb_signed", rd, 32'hFFFFFF80);
`endif
    access(1'b0, 2'd0, 1'b0, 32'h11, 32'd0, rd);
`ifdef SUBWORD_EN
    check("lbu", rd, 32'h0000007F);
`endif
    access(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, rd);
`ifdef SUBWORD_EN
    check("lh_signed", rd, 32'hFFFF80FF);
`endif
    access(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, rd);
`ifdef SUBWORD_EN
    check("sb_merge", mem[4], 32'h80FFAA01);
`else
    check("sb_rejected", mem[4], 32'h80FF7F01);
`endif

    // Error cases.
    access(1'b0, 2'd2, 1'b0, 32'h06, 32'd0, rd);
    access(1'b0, 2'd1, 1'b0, 32'h03, 32'd0, rd);
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, rd);
    access(1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, rd);
    access(1'b1, 2'd3, 1'b0, 32'h04, 32'h12345678, rd);

    // Reset during WR of a word store to 0x20.
    keep = mem[8];
    wr0 = wr_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = ~keep;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("in_wr", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_mem_write", {31'd0, mem_write}, 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd1);
    check("abort_mem_address", mem_address, 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid) seen = seen + 1;
    end
    check("abort_no_resp", seen, 0);
    check("abort_no_write", wr_cnt - wr0, 0);
    check("abort_mem_kept", mem[8], keep);
    check("abort_ready_after", {31'd0, req_ready}, 32'd1);
    @(negedge clk); #1;

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ad;
      logic [1:0]  sz;
      ad = 32'($urandom_range(0, 271));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'd2) ad = ad & ~32'd3;
        if (sz == 2'd1) ad = ad & ~32'd1;
      end
      access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, rd);
    end

    check("write_addr_aligned", bad_addr, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1);
  end

endmodule
